// File: rtl/hazard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_unit: RAW interlock for the five-stage core (no forwarding paths).  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module hazard_unit #(
  parameter bit WB_BYPASS = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             instr_valid_d_i,
  input  logic [4:0]       rs1_idx_d_i,
  input  logic [4:0]       rs2_idx_d_i,
  input  logic             rs1_used_d_i,
  input  logic             rs2_used_d_i,
  input  logic             reg_write_en_d_i,
  input  logic [4:0]       rd_idx_d_i,
  input  logic             taken_d_i,
  output logic             enable_h_o,
  output logic             bubble_h_o,
  output logic             flush_h_o,
  output logic             rs1_depended_h_o,
  output logic [CNT_W-1:0] stall_cnt_h_o
);

  localparam logic [4:0] C_X0 = 5'd0;

  typedef struct packed {
    logic       pend;
    logic [4:0] rd;
  } slot_t;

  slot_t            r_slot_e;
  slot_t            r_slot_m;
  slot_t            r_slot_w;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_rs1_haz;
  logic w_rs2_haz;
  logic w_hazard;

  // With a write-first regfile the WB slot's value is visible to ID in the same cycle.
  function automatic logic src_pending(input logic [4:0] idx, input slot_t e,
                                       input slot_t m, input slot_t w);
    return (e.pend && (e.rd == idx)) ||
           (m.pend && (m.rd == idx)) ||
           (!WB_BYPASS && w.pend && (w.rd == idx));
  endfunction

  assign w_rs1_haz = instr_valid_d_i && rs1_used_d_i && (rs1_idx_d_i != C_X0) &&
                     src_pending(rs1_idx_d_i, r_slot_e, r_slot_m, r_slot_w);
  assign w_rs2_haz = instr_valid_d_i && rs2_used_d_i && (rs2_idx_d_i != C_X0) &&
                     src_pending(rs2_idx_d_i, r_slot_e, r_slot_m, r_slot_w);
  assign w_hazard  = w_rs1_haz || w_rs2_haz;

  assign enable_h_o       = ~w_hazard;
  assign bubble_h_o       = w_hazard;
  assign rs1_depended_h_o = w_rs1_haz;
  // A redirect resolved from stale operands is suppressed until the stall clears.
  assign flush_h_o        = taken_d_i && !w_hazard && instr_valid_d_i;
  assign stall_cnt_h_o    = r_stall_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_slot_e    <= '0;
      r_slot_m    <= '0;
      r_slot_w    <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_slot_e.pend <= !w_hazard && instr_valid_d_i && reg_write_en_d_i &&
                       (rd_idx_d_i != C_X0);
      r_slot_e.rd   <= rd_idx_d_i;
      r_slot_m      <= r_slot_e;
      r_slot_w      <= r_slot_m;
      if (w_hazard && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
